alu_serial_tx: RTL and testbench
================================

Name: alu_serial_tx

Overview:
Synthesizable serial frame encoder sitting between the ALU stimulus generator and the ALU DUT serial input `sin`.
- Accepts one operation (A, B, op code, fault-injection mode) per valid/ready handshake.
- Serialises it into the ALU wire protocol: 8 data packets followed by 1 control packet carrying a CRC4.
- Replaces the behavioural send task in the BFM, so stimulus can also be driven from RTL and FPGA test harnesses.

Parameters:
- BIT_CYCLES, 1: clock cycles per serial bit; legal values 1..255.
- PKT_GAP, 0: idle bits (sin=1) inserted between consecutive packets of one frame.
- FRAME_GAP, 2: minimum idle bits after a control packet before the next frame may start.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- a_data  in  32  operand A.
- b_data  in  32  operand B.
- op_code  in  3  raw op field, sent unmodified (legal: 000 and, 001 or, 100 add, 101 sub; others pass through for error tests).
- inj  in  2  fault injection: 00 none, 01 corrupt CRC, 10 drop last A packet, 11 reserved (treated as 00).
- sin  out  1  serial line to ALU; idles high.
- busy  out  1  frame in progress, including FRAME_GAP.
- done  out  1  one-cycle pulse when the frame, including FRAME_GAP, has completed.

Behaviour:
- Reset values (asynchronous rst): sin=1, busy=0, done=0, state=IDLE, so req_ready=1 after reset. Reset mid-frame aborts immediately: sin returns to 1 asynchronously and the partial frame is lost.
- Handshake:
  - req_ready = (state==IDLE).
  - Transfer occurs on a rising edge with req_valid&&req_ready.
  - a_data, b_data, op_code and inj are registered on that edge.
  - Inputs are ignored while busy.
- Packet format, 11 bits, LSB-of-time first: start 0, type bit, 8 payload bits MSB first, stop 1.
  - Data packet: type 0, payload = byte.
  - Control packet: type 1, payload = {1'b0, op[2:0], crc[3:0]}.
- Frame order:
  - B[31:24], B[23:16], B[15:8], B[7:0], then A[31:24] .. A[7:0], then control.
  - inj=10 omits the A[7:0] packet: 7 data packets, then control.
- CRC4:
  - Polynomial x^4+x+1, init 0000, computed over the 68-bit vector {B, A, 1'b1, op}, MSB first.
  - It is computed over the full A even when inj=10.
  - inj=01 sends crc ^ 4'b1111.
- Latency: the first start bit is driven on the edge after acceptance. Each bit is held for exactly BIT_CYCLES cycles.
- FSM states:
  - IDLE -> DATA on accept; packet counter = 0.
  - DATA: shift 11 bits. After the stop bit:
    - to PGAP if PKT_GAP>0, else to the next packet.
    - After packet 7 (or packet 6 when inj=10) -> CTL.
  - PGAP: PKT_GAP idle bits -> DATA or CTL.
  - CTL: shift 11 bits -> FGAP.
  - FGAP: FRAME_GAP idle bits -> IDLE. done pulses on the IDLE-entry edge, and req_ready rises in the same cycle.
  - FRAME_GAP=0: go CTL->IDLE directly.
- Counters:
  - bit counter 0..10; cycle counter 0..BIT_CYCLES-1; packet counter 0..7; gap counter sized for the maximum of PKT_GAP and FRAME_GAP.
  - Counters wrap to 0 only on state transitions; no free-running wrap.
- Frame length, normal: 99*BIT_CYCLES + 8*PKT_GAP*BIT_CYCLES + FRAME_GAP*BIT_CYCLES cycles from the first start bit to done.
- Back-to-back: if req_valid is held high, the next transfer happens on the cycle done pulses. No request is lost or duplicated.

Decomposition:
- alu_pkg additions:
  - op code constants.
  - inj_t enum (INJ_NONE, INJ_CRC, INJ_DROP).
  - packet constants: PKT_BITS=11, DATA_PKTS=8.
  - function crc4(bit [67:0]) returning bit [3:0], shared with the scoreboard.
- One sub-module, alu_tx_pkt_shifter: loads an 11-bit packet, applies BIT_CYCLES timing and drives sin, with pkt_load/pkt_done handshake. The top level holds only the frame FSM and packet counter.

Test Plan:
- A=0, B=0, op=000, inj=00, BIT_CYCLES=1 -> 8 packets of 00000000001, then control 0 1 0 000 1011 1; done exactly 99+2 cycles after the first start bit.
- A=32'hFFFF_FFFF, B=32'h1234_5678, op=100 -> B bytes 12, 34, 56, 78, then FF x4, in order; CRC matches crc4() from the package.
- Same as the first case with inj=01 -> control CRC 0100. With inj=10 -> only 7 data packets; the last data packet is A[15:8].
- BIT_CYCLES=3, PKT_GAP=1 -> every bit held 3 cycles and 3 high cycles between packets; req_ready low until done.
- req_valid held high for 3 requests -> exactly 3 frames; each accept occurs on the done cycle; sin high for FRAME_GAP bits between frames.
- rst asserted mid-packet 4 -> sin=1 and busy=0 immediately; after release, a new request produces a complete, correct frame.

Source files
------------

// File: rtl/alu_serial_tx_pkg.sv
// ---------------------------------------------------------------------------
// alu_serial_tx_pkg
// Shared definitions for the ALU serial frame encoder: op codes, the fault
// injection enum, packet geometry, the CRC4 used in the control packet and
// the helper that lays a packet out in transmit order.
// ---------------------------------------------------------------------------
package alu_serial_tx_pkg;

  // ALU op codes carried unmodified in the control packet
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  // Fault injection modes; the reserved encoding 2'b11 is folded to INJ_NONE
  typedef enum logic [1:0] {
    INJ_NONE = 2'b00,
    INJ_CRC  = 2'b01,
    INJ_DROP = 2'b10
  } inj_t;

  localparam int PKT_BITS  = 11;
  localparam int DATA_PKTS = 8;

  // CRC4, polynomial x^4+x+1, init 0, MSB of the vector first
  function automatic bit [3:0] crc4(input bit [67:0] vec);
    bit [3:0] c;
    bit       fb;
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ vec[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  // Packet in transmit order: bit 0 goes on the wire first.
  // start 0, type, payload MSB..LSB, stop 1.
  function automatic logic [PKT_BITS-1:0] make_pkt(input logic       pkt_type,
                                                   input logic [7:0] payload);
    logic [PKT_BITS-1:0] w;
    w[0] = 1'b0;
    w[1] = pkt_type;
    for (int i = 0; i < 8; i++) begin
      w[2+i] = payload[7-i];
    end
    w[10] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/alu_tx_pkt_shifter.sv
// ---------------------------------------------------------------------------
// alu_tx_pkt_shifter
// Serialises one slot onto the line: either an 11-bit packet or a run of
// idle (high) bits used for the inter-packet and inter-frame gaps. Each bit
// is held for BIT_CYCLES clocks.
//   pkt_load_i   load a new slot this edge (legal when idle or on pkt_done_o)
//   pkt_word_i   slot bits, bit 0 sent first (all ones for an idle run)
//   pkt_nbits_i  slot length in bits (11 for a packet, N for a gap)
//   pkt_done_o   high during the final cycle of the slot
//   sin_o        registered serial line, idles high
// ---------------------------------------------------------------------------
module alu_tx_pkt_shifter
  import alu_serial_tx_pkg::*;
#(
  parameter int BIT_CYCLES = 1,
  parameter int CW         = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pkt_load_i,
  input  logic [PKT_BITS-1:0] pkt_word_i,
  input  logic [CW-1:0]       pkt_nbits_i,
  output logic                pkt_done_o,
  output logic                sin_o
);

  logic                sin_q, sin_d;
  logic                act_q, act_d;
  logic [PKT_BITS-1:0] sh_q, sh_d;
  logic [CW-1:0]       rem_q, rem_d;
  logic [7:0]          cyc_q, cyc_d;
  logic                bit_end_s;

  assign bit_end_s  = (cyc_q == 8'(BIT_CYCLES - 1));
  assign pkt_done_o = act_q & bit_end_s & (rem_q == {CW{1'b0}});
  assign sin_o      = sin_q;

  // Next-state: load a slot, advance one bit per bit period, or idle high
  always_comb begin
    sin_d = sin_q;
    act_d = act_q;
    sh_d  = sh_q;
    rem_d = rem_q;
    cyc_d = cyc_q;
    if (pkt_load_i) begin
      sin_d = pkt_word_i[0];
      sh_d  = {1'b1, pkt_word_i[PKT_BITS-1:1]};
      rem_d = pkt_nbits_i - CW'(1'b1);
      cyc_d = 8'd0;
      act_d = 1'b1;
    end else if (act_q && bit_end_s) begin
      cyc_d = 8'd0;
      if (rem_q == {CW{1'b0}}) begin
        act_d = 1'b0;
        sin_d = 1'b1;
      end else begin
        // refill with ones so gap runs longer than 11 bits stay high
        sin_d = sh_q[0];
        sh_d  = {1'b1, sh_q[PKT_BITS-1:1]};
        rem_d = rem_q - CW'(1'b1);
      end
    end else if (act_q) begin
      cyc_d = cyc_q + 8'd1;
    end else begin
      sin_d = 1'b1;
    end
  end

  // State registers; reset forces the line high at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_q <= 1'b1;
      act_q <= 1'b0;
      sh_q  <= {PKT_BITS{1'b1}};
      rem_q <= {CW{1'b0}};
      cyc_q <= 8'd0;
    end else begin
      sin_q <= sin_d;
      act_q <= act_d;
      sh_q  <= sh_d;
      rem_q <= rem_d;
      cyc_q <= cyc_d;
    end
  end

endmodule

// File: rtl/alu_serial_tx.sv
// ---------------------------------------------------------------------------
// alu_serial_tx
// Frame encoder for the ALU serial input. Accepts one operation per
// valid/ready handshake and sends 8 data packets (B then A, MSB byte first)
// followed by a control packet {0, op, crc4}, with optional gaps.
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready == FSM idle)
//   a_data, b_data        operands; op_code raw op field; inj fault mode
//   sin                   serial line, idles high
//   busy                  frame in progress including the frame gap
//   done                  one-cycle pulse as the FSM returns to idle
// ---------------------------------------------------------------------------
module alu_serial_tx
  import alu_serial_tx_pkg::*;
#(
  parameter int BIT_CYCLES = 1,
  parameter int PKT_GAP    = 0,
  parameter int FRAME_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] a_data,
  input  logic [31:0] b_data,
  input  logic [2:0]  op_code,
  input  logic [1:0]  inj,
  output logic        sin,
  output logic        busy,
  output logic        done
);

  // The shifter's bit counter also times the gaps, so it must span both.
  localparam int GAP_MAX  = (PKT_GAP > FRAME_GAP) ? PKT_GAP : FRAME_GAP;
  localparam int MAX_BITS = (GAP_MAX > PKT_BITS) ? GAP_MAX : PKT_BITS;
  localparam int CW       = $clog2(MAX_BITS + 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
  localparam logic [2:0] ST_PGAP = 3'd2;
  localparam logic [2:0] ST_CTL  = 3'd3;
  localparam logic [2:0] ST_FGAP = 3'd4;

  localparam logic [PKT_BITS-1:0] IDLE_WORD = {PKT_BITS{1'b1}};
  localparam logic [2:0]          LAST_PKT  = 3'(DATA_PKTS - 1);

  logic [2:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        start_q, start_d;
  logic        done_q, done_d;
  logic        busy_q;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [2:0]  op_q, op_d;
  inj_t        inj_q, inj_d;
  logic [3:0]  crc_q, crc_d;

  logic                load_s;
  logic [PKT_BITS-1:0] word_s;
  logic [CW-1:0]       nbits_s;
  logic                pkt_done_s;
  logic                last_s;
  logic [2:0]          cnt_inc_s;
  logic [63:0]         frame_s;
  logic [PKT_BITS-1:0] ctl_word_s;

  // Byte idx of the {B, A} frame, idx 0 = B[31:24]
  function automatic logic [7:0] pick_byte(input logic [63:0] frame, input logic [2:0] idx);
    logic [7:0] r;
    case (idx)
      3'd0:    r = frame[63:56];
      3'd1:    r = frame[55:48];
      3'd2:    r = frame[47:40];
      3'd3:    r = frame[39:32];
      3'd4:    r = frame[31:24];
      3'd5:    r = frame[23:16];
      3'd6:    r = frame[15:8];
      3'd7:    r = frame[7:0];
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign frame_s    = {b_q, a_q};
  assign cnt_inc_s  = cnt_q + 3'd1;
  // drop mode ends the data phase one packet early, losing A[7:0]
  assign last_s     = (cnt_q == ((inj_q == INJ_DROP) ? (LAST_PKT - 3'd1) : LAST_PKT));
  assign ctl_word_s = make_pkt(1'b1, {1'b0, op_q,
                               (inj_q == INJ_CRC) ? (crc_q ^ 4'b1111) : crc_q});

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = busy_q;
  assign done      = done_q;

  // Frame FSM: picks the next slot for the shifter as each one finishes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    done_d  = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    inj_d   = inj_q;
    crc_d   = crc_q;
    load_s  = 1'b0;
    word_s  = IDLE_WORD;
    nbits_s = CW'(PKT_BITS);
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_DATA;
          cnt_d   = 3'd0;
          start_d = 1'b1;
          a_d     = a_data;
          b_d     = b_data;
          op_d    = op_code;
          crc_d   = crc4({b_data, a_data, 1'b1, op_code});
          case (inj)
            2'b01:   inj_d = INJ_CRC;
            2'b10:   inj_d = INJ_DROP;
            default: inj_d = INJ_NONE;
          endcase
        end else begin
          start_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (start_q) begin
          // first packet goes out one edge after acceptance
          load_s  = 1'b1;
          word_s  = make_pkt(1'b0, pick_byte(frame_s, cnt_q));
          start_d = 1'b0;
        end else if (pkt_done_s) begin
          load_s = 1'b1;
          if (PKT_GAP > 0) begin
            state_d = ST_PGAP;
            nbits_s = CW'(PKT_GAP);
          end else if (last_s) begin
            state_d = ST_CTL;
            word_s  = ctl_word_s;
          end else begin
            cnt_d  = cnt_inc_s;
            word_s = make_pkt(1'b0, pick_byte(frame_s, cnt_inc_s));
          end
        end else begin
          load_s = 1'b0;
        end
      end
      ST_PGAP: begin
        if (pkt_done_s) begin
          load_s = 1'b1;
          if (last_s) begin
            state_d = ST_CTL;
            word_s  = ctl_word_s;
          end else begin
            state_d = ST_DATA;
            cnt_d   = cnt_inc_s;
            word_s  = make_pkt(1'b0, pick_byte(frame_s, cnt_inc_s));
          end
        end else begin
          load_s = 1'b0;
        end
      end
      ST_CTL: begin
        if (pkt_done_s) begin
          if (FRAME_GAP > 0) begin
            state_d = ST_FGAP;
            load_s  = 1'b1;
            nbits_s = CW'(FRAME_GAP);
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      ST_FGAP: begin
        if (pkt_done_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
        start_d = 1'b0;
      end
    endcase
  end

  // FSM, operand and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      a_q     <= 32'h0000_0000;
      b_q     <= 32'h0000_0000;
      op_q    <= 3'b000;
      inj_q   <= INJ_NONE;
      crc_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      done_q  <= done_d;
      busy_q  <= (state_d != ST_IDLE);
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      inj_q   <= inj_d;
      crc_q   <= crc_d;
    end
  end

  alu_tx_pkt_shifter #(
    .BIT_CYCLES (BIT_CYCLES),
    .CW         (CW)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .pkt_load_i  (load_s),
    .pkt_word_i  (word_s),
    .pkt_nbits_i (nbits_s),
    .pkt_done_o  (pkt_done_s),
    .sin_o       (sin)
  );

endmodule

// File: tb/tb_alu_serial_tx.sv
`timescale 1ns/1ps
module tb_alu_serial_tx;
  import alu_serial_tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] a_in, b_in;
  logic [2:0]  op_in;
  logic [1:0]  inj_in;
  logic        use3;

  logic rdy1, sin1, busy1, done1;
  logic rdy3, sin3, busy3, done3;
  logic mon_sin, mon_busy, mon_done, mon_rdy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [1:0]  inj;
    logic [7:0]  ctl;   // expected control payload {0, op, crc}
  } vec_t;

  vec_t vt[6];
  vec_t rv;

  always #5 clk = ~clk;

  alu_serial_tx #(.BIT_CYCLES(1), .PKT_GAP(0), .FRAME_GAP(2)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~use3), .req_ready(rdy1),
    .a_data(a_in), .b_data(b_in), .op_code(op_in), .inj(inj_in),
    .sin(sin1), .busy(busy1), .done(done1)
  );

  alu_serial_tx #(.BIT_CYCLES(3), .PKT_GAP(1), .FRAME_GAP(2)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid & use3), .req_ready(rdy3),
    .a_data(a_in), .b_data(b_in), .op_code(op_in), .inj(inj_in),
    .sin(sin3), .busy(busy3), .done(done3)
  );

  assign mon_sin  = use3 ? sin3  : sin1;
  assign mon_busy = use3 ? busy3 : busy1;
  assign mon_done = use3 ? done3 : done1;
  assign mon_rdy  = use3 ? rdy3  : rdy1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Remainder of (vector * x^4) divided by x^4+x+1
  function automatic logic [3:0] tb_crc(input logic [67:0] v);
    logic [71:0] r;
    r = {v, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  // Packet as seen on the wire, index 0 = first bit in time
  function automatic logic [10:0] exp_pkt(input logic t, input logic [7:0] p);
    return {1'b1, p[0], p[1], p[2], p[3], p[4], p[5], p[6], p[7], t, 1'b0};
  endfunction

  function automatic logic [7:0] exp_byte(input logic [31:0] a, input logic [31:0] b, input int k);
    logic [63:0] f, s;
    f = {b, a};
    s = f >> (8 * (7 - k));
    return s[7:0];
  endfunction

  // Sends one request and walks the whole frame cycle by cycle.
  // Entry and exit are at a falling edge with the DUT idle (exit = done cycle).
  task automatic run_frame(input vec_t v, input bit hold, input string tag);
    int bc, pg, npk, gap;
    logic [10:0] got, expw;
    bit held_ok, quiet_ok, gap_ok;
    bc  = use3 ? 3 : 1;
    pg  = use3 ? 1 : 0;
    npk = (v.inj == 2'b10) ? 7 : 8;
    held_ok = 1'b1; quiet_ok = 1'b1; gap_ok = 1'b1;
    a_in = v.a; b_in = v.b; op_in = v.op; inj_in = v.inj;
    req_valid = 1'b1;
    chk({tag, "_ready_before"}, mon_rdy, 1'b1);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    a_in = ~v.a; b_in = ~v.b; op_in = ~v.op; inj_in = ~v.inj;
    chk({tag, "_busy_after_accept"}, mon_busy, 1'b1);
    chk({tag, "_ready_low"}, mon_rdy, 1'b0);
    chk({tag, "_sin_idle_latency"}, mon_sin, 1'b1);
    @(negedge clk);
    for (int p = 0; p <= npk; p++) begin
      expw = (p < npk) ? exp_pkt(1'b0, exp_byte(v.a, v.b, p)) : exp_pkt(1'b1, v.ctl);
      got  = 11'h000;
      for (int j = 0; j < 11; j++) begin
        for (int c = 0; c < bc; c++) begin
          if (c == 0) got[j] = mon_sin;
          else if (mon_sin !== got[j]) held_ok = 1'b0;
          if (mon_rdy !== 1'b0 || mon_done !== 1'b0 || mon_busy !== 1'b1) quiet_ok = 1'b0;
          @(negedge clk);
        end
      end
      chk($sformatf("%s_pkt%0d", tag, p), {21'h0, got}, {21'h0, expw});
      gap = (p < npk) ? pg * bc : 2 * bc;
      for (int g = 0; g < gap; g++) begin
        if (mon_sin !== 1'b1) gap_ok = 1'b0;
        if (mon_rdy !== 1'b0 || mon_done !== 1'b0 || mon_busy !== 1'b1) quiet_ok = 1'b0;
        @(negedge clk);
      end
    end
    chk({tag, "_bit_hold"}, {31'h0, held_ok}, 32'h1);
    chk({tag, "_busy_until_done"}, {31'h0, quiet_ok}, 32'h1);
    chk({tag, "_gaps_high"}, {31'h0, gap_ok}, 32'h1);
    chk({tag, "_done_pulse"}, mon_done, 1'b1);
    chk({tag, "_ready_at_done"}, mon_rdy, 1'b1);
    chk({tag, "_busy_at_done"}, mon_busy, 1'b0);
    if (!hold) begin
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, mon_done, 1'b0);
      chk({tag, "_idle_after"}, mon_busy, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{a: 32'h0000_0000, b: 32'h0000_0000, op: 3'b000, inj: 2'b00, ctl: 8'h0B};
    vt[1] = '{a: 32'hFFFF_FFFF, b: 32'h1234_5678, op: 3'b100, inj: 2'b00,
              ctl: {1'b0, 3'b100, tb_crc({32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 3'b100})}};
    vt[2] = '{a: 32'h0000_0000, b: 32'h0000_0000, op: 3'b000, inj: 2'b01, ctl: 8'h04};
    vt[3] = '{a: 32'h0000_0000, b: 32'h0000_0000, op: 3'b000, inj: 2'b10, ctl: 8'h0B};
    vt[4] = '{a: 32'h0000_0000, b: 32'h0000_0000, op: 3'b101, inj: 2'b11, ctl: 8'h54};
    vt[5] = '{a: 32'hA5A5_0F0F, b: 32'hDEAD_BEEF, op: 3'b111, inj: 2'b10,
              ctl: {1'b0, 3'b111, tb_crc({32'hDEAD_BEEF, 32'hA5A5_0F0F, 1'b1, 3'b111})}};

    rst = 1'b1; req_valid = 1'b0; use3 = 1'b0;
    a_in = 32'h0; b_in = 32'h0; op_in = 3'b000; inj_in = 2'b00;
    #3;
    chk("rst_sin1", sin1, 1'b1);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_done1", done1, 1'b0);
    chk("rst_ready1", rdy1, 1'b1);
    chk("rst_sin3", sin3, 1'b1);
    chk("rst_ready3", rdy3, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready1", rdy1, 1'b1);
    chk("post_rst_sin1", sin1, 1'b1);

    // Package CRC against the bench's polynomial division
    chk("crc4_pkg_a", {28'h0, 4'(crc4({32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 3'b100}))},
        {28'h0, tb_crc({32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 3'b100})});
    chk("crc4_pkg_b", {28'h0, 4'(crc4({32'hDEAD_BEEF, 32'hA5A5_0F0F, 1'b1, 3'b111}))},
        {28'h0, tb_crc({32'hDEAD_BEEF, 32'hA5A5_0F0F, 1'b1, 3'b111})});

    for (int i = 0; i < 6; i++) begin
      run_frame(vt[i], 1'b0, $sformatf("v%0d", i));
    end

    // Slow bit rate with packet gaps
    use3 = 1'b1;
    run_frame(vt[1], 1'b0, "bc3");
    use3 = 1'b0;

    // Back-to-back with req_valid held high
    run_frame(vt[0], 1'b1, "b2b0");
    run_frame(vt[1], 1'b1, "b2b1");
    run_frame(vt[5], 1'b1, "b2b2");
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_no_extra_frame", busy1, 1'b0);
    chk("b2b_sin_idle", sin1, 1'b1);

    // Reset in the middle of packet 4 (A[31:24] = 0, so sin is low there)
    rv = '{a: 32'h0000_0000, b: 32'hFFFF_FFFF, op: 3'b001, inj: 2'b00, ctl: 8'h00};
    a_in = rv.a; b_in = rv.b; op_in = rv.op; inj_in = rv.inj;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (50) @(negedge clk);
    chk("rst_mid_pre_sin_low", sin1, 1'b0);
    chk("rst_mid_pre_busy", busy1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_sin", sin1, 1'b1);
    chk("rst_mid_busy", busy1, 1'b0);
    chk("rst_mid_done", done1, 1'b0);
    chk("rst_mid_ready", rdy1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    run_frame(vt[1], 1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
